// File: rtl/i2c_core_arbiter.sv
// Round-robin owner of the I2C pin pair shared by two ap_ctrl_hs HLS cores.
// Sequences the winner's ap_start handshake, forwards its pin writes and guards each run with a watchdog.
module i2c_core_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned TO_W           = 20
) (
   input  logic       ap_clk,
   input  logic       ap_rst,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       busy,
   output logic [1:0] done_pulse,
   output logic       timeout,
   output logic       c0_ap_start,
   input  logic       c0_ap_done,
   input  logic       c0_ap_idle,
   input  logic       c0_ap_ready,
   input  logic [7:0] c0_SDA,
   input  logic [7:0] c0_SCL,
   input  logic       c0_SDA_ap_vld,
   input  logic       c0_SCL_ap_vld,
   output logic       c1_ap_start,
   input  logic       c1_ap_done,
   input  logic       c1_ap_idle,
   input  logic       c1_ap_ready,
   input  logic [7:0] c1_SDA,
   input  logic [7:0] c1_SCL,
   input  logic       c1_SDA_ap_vld,
   input  logic       c1_SCL_ap_vld,
   output logic       sda_o,
   output logic       scl_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic [1:0]      start_q, start_d;
   logic [1:0]      done_pulse_q, done_pulse_d;
   logic            own_q, own_d;
   logic            last_q, last_d;
   logic            timeout_q, timeout_d;
   logic            sda_q, sda_d;
   logic            scl_q, scl_d;
   logic [TO_W-1:0] cnt_q, cnt_d;

   logic own_ready, own_done, own_sda_vld, own_scl_vld, own_sda, own_scl;
   logic win, done_hit;

   // Status and pin strobes of whichever core currently owns the bus.
   always_comb begin
      if (own_q) begin
         own_ready   = c1_ap_ready;
         own_done    = c1_ap_done;
         own_sda_vld = c1_SDA_ap_vld;
         own_scl_vld = c1_SCL_ap_vld;
         own_sda     = c1_SDA[0];
         own_scl     = c1_SCL[0];
      end else begin
         own_ready   = c0_ap_ready;
         own_done    = c0_ap_done;
         own_sda_vld = c0_SDA_ap_vld;
         own_scl_vld = c0_SCL_ap_vld;
         own_sda     = c0_SDA[0];
         own_scl     = c0_SCL[0];
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      start_d      = start_q;
      done_pulse_d = 2'b00;
      own_d        = own_q;
      last_d       = last_q;
      timeout_d    = 1'b0;
      sda_d        = sda_q;
      scl_d        = scl_q;
      cnt_d        = cnt_q;
      win          = 1'b0;
      done_hit     = 1'b0;

      case (state_q)
         IDLE: begin
            sda_d   = 1'b1;
            scl_d   = 1'b1;
            grant_d = 2'b00;
            start_d = 2'b00;
            if (|req) begin
               // On a tie the core that did not own the bus last time wins.
               win     = (req == 2'b11) ? ~last_q : req[1];
               own_d   = win;
               grant_d = win ? 2'b10 : 2'b01;
               start_d = win ? 2'b10 : 2'b01;
               cnt_d   = '0;
               state_d = START;
            end
         end

         START, RUN: begin
            cnt_d = cnt_q + TO_W'(1);
            if (own_sda_vld) sda_d = own_sda;
            if (own_scl_vld) scl_d = own_scl;

            if (state_q == START) begin
               done_hit = own_ready && own_done;
               if (own_ready) begin
                  start_d = 2'b00;
                  state_d = own_done ? FINISH : RUN;
               end
            end else begin
               done_hit = own_done;
               if (own_done) state_d = FINISH;
            end

            // A done seen on the last permitted cycle still completes normally.
            if (!done_hit && (cnt_q == TO_LAST)) begin
               timeout_d = 1'b1;
               start_d   = 2'b00;
               last_d    = own_q;
               grant_d   = 2'b00;
               sda_d     = 1'b1;
               scl_d     = 1'b1;
               state_d   = IDLE;
            end
         end

         FINISH: begin
            done_pulse_d = own_q ? 2'b10 : 2'b01;
            last_d       = own_q;
            grant_d      = 2'b00;
            start_d      = 2'b00;
            sda_d        = 1'b1;
            scl_d        = 1'b1;
            state_d      = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q      <= IDLE;
         grant_q      <= 2'b00;
         start_q      <= 2'b00;
         done_pulse_q <= 2'b00;
         own_q        <= 1'b0;
         last_q       <= 1'b1;
         timeout_q    <= 1'b0;
         sda_q        <= 1'b1;
         scl_q        <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         start_q      <= start_d;
         done_pulse_q <= done_pulse_d;
         own_q        <= own_d;
         last_q       <= last_d;
         timeout_q    <= timeout_d;
         sda_q        <= sda_d;
         scl_q        <= scl_d;
         cnt_q        <= cnt_d;
      end
   end

   assign grant       = grant_q;
   assign busy        = (state_q != IDLE);
   assign done_pulse  = done_pulse_q;
   assign timeout     = timeout_q;
   assign c0_ap_start = start_q[0];
   assign c1_ap_start = start_q[1];
   assign sda_o       = sda_q;
   assign scl_o       = scl_q;

   // ap_idle and the upper pin bits carry no sequencing information.
   logic unused_inputs;
   assign unused_inputs = ^{c0_ap_idle, c1_ap_idle, c0_SDA[7:1], c0_SCL[7:1],
                            c1_SDA[7:1], c1_SCL[7:1]};

endmodule

// File: tb/tb_i2c_core_arbiter.sv
// Directed bench for i2c_core_arbiter: handshake, pin forwarding, round-robin,
// ready+done collapse, watchdog, foreign strobes and mid-run reset.
module tb_i2c_core_arbiter;

   logic       ap_clk = 1'b0;
   logic       ap_rst;
   logic [1:0] req;
   logic [1:0] grant;
   logic       busy;
   logic [1:0] done_pulse;
   logic       timeout;
   logic       c0_ap_start, c0_ap_done, c0_ap_idle, c0_ap_ready;
   logic [7:0] c0_SDA, c0_SCL;
   logic       c0_SDA_ap_vld, c0_SCL_ap_vld;
   logic       c1_ap_start, c1_ap_done, c1_ap_idle, c1_ap_ready;
   logic [7:0] c1_SDA, c1_SCL;
   logic       c1_SDA_ap_vld, c1_SCL_ap_vld;
   logic       sda_o, scl_o;

   int n_checks = 0;
   int n_fails  = 0;
   logic [1:0] exp_g [3];

   always #10 ap_clk = ~ap_clk;

   i2c_core_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .req(req), .grant(grant), .busy(busy),
      .done_pulse(done_pulse), .timeout(timeout),
      .c0_ap_start(c0_ap_start), .c0_ap_done(c0_ap_done), .c0_ap_idle(c0_ap_idle),
      .c0_ap_ready(c0_ap_ready), .c0_SDA(c0_SDA), .c0_SCL(c0_SCL),
      .c0_SDA_ap_vld(c0_SDA_ap_vld), .c0_SCL_ap_vld(c0_SCL_ap_vld),
      .c1_ap_start(c1_ap_start), .c1_ap_done(c1_ap_done), .c1_ap_idle(c1_ap_idle),
      .c1_ap_ready(c1_ap_ready), .c1_SDA(c1_SDA), .c1_SCL(c1_SCL),
      .c1_SDA_ap_vld(c1_SDA_ap_vld), .c1_SCL_ap_vld(c1_SCL_ap_vld),
      .sda_o(sda_o), .scl_o(scl_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic clr_cores();
      c0_ap_done = 0; c0_ap_idle = 1; c0_ap_ready = 0;
      c0_SDA = 8'h00; c0_SCL = 8'h00; c0_SDA_ap_vld = 0; c0_SCL_ap_vld = 0;
      c1_ap_done = 0; c1_ap_idle = 1; c1_ap_ready = 0;
      c1_SDA = 8'h00; c1_SCL = 8'h00; c1_SDA_ap_vld = 0; c1_SCL_ap_vld = 0;
   endtask

   task automatic do_reset();
      ap_rst = 1; req = 2'b00;
      clr_cores();
      tick(); tick();
      ap_rst = 0;
      tick();
   endtask

   task automatic wait_grant(input int budget);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while ((grant == 2'b00) && (k < budget));
      check("grant_seen", {31'b0, grant != 2'b00}, 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done_pulse, 0);
      check({tag, "_tmo"}, timeout, 0);
      check({tag, "_start"}, {c1_ap_start, c0_ap_start}, 0);
      check({tag, "_sda"}, sda_o, 1);
      check({tag, "_scl"}, scl_o, 1);
   endtask

   initial begin
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;

      // Reset and a single core-0 run with pin writes
      do_reset();
      check_reset_vals("rst");
      req = 2'b01;
      tick();
      check("t1_grant", grant, 2'b01);
      check("t1_start_e1", c0_ap_start, 1);
      check("t1_busy", busy, 1);
      req = 2'b00;
      tick();
      check("t1_start_e2", c0_ap_start, 1);
      tick();
      check("t1_start_e3", c0_ap_start, 1);
      c0_ap_ready = 1; c0_SDA = 8'hFE; c0_SDA_ap_vld = 1;
      tick();
      check("t1_start_low", c0_ap_start, 0);
      check("t1_sda0", sda_o, 0);
      check("t1_scl_hold", scl_o, 1);
      c0_ap_ready = 0; c0_SDA_ap_vld = 0; c0_SCL = 8'h00; c0_SCL_ap_vld = 1;
      tick();
      check("t1_scl0", scl_o, 0);
      check("t1_sda_keep", sda_o, 0);
      c0_SCL_ap_vld = 0; c0_SDA = 8'h01; c0_SDA_ap_vld = 1;
      tick();
      check("t1_sda1", sda_o, 1);
      check("t1_scl_keep", scl_o, 0);
      c0_SDA_ap_vld = 0;
      tick(); tick(); tick();
      c0_ap_done = 1;
      tick();
      check("t1_fin_pulse", done_pulse, 0);
      check("t1_fin_grant", grant, 2'b01);
      c0_ap_done = 0;
      tick();
      check("t1_done", done_pulse, 2'b01);
      check("t1_rel_grant", grant, 0);
      check("t1_rel_sda", sda_o, 1);
      check("t1_rel_scl", scl_o, 1);
      check("t1_idle", busy, 0);
      tick();
      check("t1_done_once", done_pulse, 0);

      // Round-robin with both requests held
      do_reset();
      req = 2'b11;
      for (int i = 0; i < 3; i++) begin
         wait_grant(8);
         check("rr_grant", grant, exp_g[i]);
         check("rr_start", {c1_ap_start, c0_ap_start}, exp_g[i]);
         c0_ap_ready = exp_g[i][0]; c1_ap_ready = exp_g[i][1];
         tick();
         check("rr_start_low", {c1_ap_start, c0_ap_start}, 0);
         c0_ap_ready = 0; c1_ap_ready = 0;
         c0_ap_done = exp_g[i][0]; c1_ap_done = exp_g[i][1];
         tick();
         c0_ap_done = 0; c1_ap_done = 0;
         tick();
         check("rr_done", done_pulse, exp_g[i]);
      end
      req = 2'b00;
      tick();

      // Core 1: ready and done together, with a strobe in that cycle
      req = 2'b10;
      wait_grant(8);
      check("t3_grant", grant, 2'b10);
      check("t3_start", {c1_ap_start, c0_ap_start}, 2'b10);
      req = 2'b00;
      c1_ap_ready = 1; c1_ap_done = 1; c1_SDA = 8'h00; c1_SDA_ap_vld = 1;
      tick();
      check("t3_start_low", c1_ap_start, 0);
      check("t3_fin_pulse", done_pulse, 0);
      check("t3_sda_w_done", sda_o, 0);
      check("t3_busy", busy, 1);
      clr_cores();
      tick();
      check("t3_done", done_pulse, 2'b10);
      check("t3_rel_sda", sda_o, 1);
      check("t3_rel_grant", grant, 0);

      // Watchdog: core 0 never becomes ready, core 1 waits its turn
      req = 2'b11;
      wait_grant(8);
      check("t4_grant", grant, 2'b01);
      c0_SDA = 8'h00; c0_SDA_ap_vld = 1;
      tick();
      check("t4_sda0", sda_o, 0);
      c0_SDA_ap_vld = 0;
      for (int k = 2; k <= 15; k++) begin
         tick();
         check("t4_no_tmo", timeout, 0);
      end
      check("t4_start_held", c0_ap_start, 1);
      tick();
      check("t4_tmo", timeout, 1);
      check("t4_no_done", done_pulse, 0);
      check("t4_grant0", grant, 0);
      check("t4_rel_sda", sda_o, 1);
      check("t4_start0", c0_ap_start, 0);
      check("t4_idle", busy, 0);
      tick();
      check("t4_tmo_once", timeout, 0);
      check("t4_next", grant, 2'b10);
      req = 2'b00;
      c1_ap_ready = 1; c1_ap_done = 1;
      tick();
      clr_cores();
      tick();
      check("t4_c1_done", done_pulse, 2'b10);

      // Foreign strobes during core 0's run
      req = 2'b01;
      wait_grant(8);
      check("t5_grant", grant, 2'b01);
      req = 2'b00;
      c0_ap_ready = 1; c0_SDA = 8'h00; c0_SDA_ap_vld = 1;
      tick();
      check("t5_sda0", sda_o, 0);
      clr_cores();
      for (int i = 0; i < 4; i++) begin
         c1_SDA = (i % 2 == 0) ? 8'h01 : 8'hFF;
         c1_SCL = 8'h00;
         c1_SDA_ap_vld = 1; c1_SCL_ap_vld = (i % 2 == 0);
         tick();
         check("t5_sda_kept", sda_o, 0);
         check("t5_scl_kept", scl_o, 1);
      end
      clr_cores();

      // Reset while running with SDA held low
      ap_rst = 1; req = 2'b11;
      tick();
      check_reset_vals("t6");
      ap_rst = 0;
      tick();
      check("t6_first_win", grant, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/i2c_core_arbiter.md
Name: i2c_core_arbiter

Overview:
- Sequences and shares the single I2C pin pair between two HLS cores that use the ap_ctrl_hs protocol. Core 0 is the display core; core 1 is a second bus user, such as a sensor or config writer.
- Grants the bus round-robin, drives the winner's ap_start handshake, and forwards its SDA/SCL ap_vld writes onto registered pin outputs.
- Reports completion and enforces a timeout watchdog.
- Sits between the top level (request sources) and the two cores.

Parameters:
TIMEOUT_CYCLES, 1000000, maximum cycles from grant to ap_done before the run is abandoned (must be >= 2)
TO_W, 20, timeout counter width (must hold TIMEOUT_CYCLES-1)

Ports:
ap_clk  in  1  system clock, 50 MHz
ap_rst  in  1  synchronous active-high reset
req  in  2  level request to run core n; sampled only in IDLE
grant  out  2  one-hot owner of bus; 0 when idle
busy  out  1  high in any state except IDLE
done_pulse  out  2  one-cycle pulse when core n finishes normally
timeout  out  1  one-cycle pulse when a run is abandoned
c0_ap_start  out  1  start to core 0
c0_ap_done, c0_ap_idle, c0_ap_ready  in  1 each  core 0 status
c0_SDA, c0_SCL  in  8 each  core 0 pin values; bit 0 is the pin level
c0_SDA_ap_vld, c0_SCL_ap_vld  in  1 each  core 0 write strobes
c1_*  same set as c0_* for core 1
sda_o  out  1  registered SDA level; 1 = released/high
scl_o  out  1  registered SCL level; 1 = released/high

Behaviour:
- Reset: all outputs and state are cleared on ap_rst sampled high, regardless of state.
  - grant=0, busy=0, done_pulse=0, timeout=0, cN_ap_start=0, sda_o=1, scl_o=1.
  - FSM goes to IDLE; last pointer=1, so core 0 wins the first tie; timeout counter=0.
- FSM states: IDLE, START, RUN, FINISH.
- IDLE:
  - Bus released (sda_o=scl_o=1).
  - If any req bit is high, the winner is chosen. With a single request, that requester wins. With both requests, the core != last wins.
  - Next cycle: grant=onehot(winner), cN_ap_start=1, state=START, counter=0.
  - With no request, the block stays in IDLE.
- START:
  - cN_ap_start is held high until cN_ap_ready is sampled 1.
  - Once ready is sampled, start is low from the next cycle and the state moves to RUN.
  - If ap_done is sampled in the same cycle as ap_ready, the state goes directly to FINISH.
- RUN: waits for cN_ap_done=1, then goes to FINISH.
- Pin forwarding (START and RUN, granted core only):
  - A cycle with cN_SDA_ap_vld=1 sets sda_o <= cN_SDA[0] on the next edge; SCL is handled the same way, independently.
  - SDA and SCL strobes may coincide; both are applied.
  - Strobes from the non-granted core are ignored at all times.
  - A strobe in the same cycle as ap_done is still applied.
- FINISH (1 cycle):
  - done_pulse[n]=1, last=n, grant=0, sda_o=scl_o=1 (release), state=IDLE.
  - In IDLE the next grant can issue one cycle later, so a grant is followed by at least one idle cycle.
- Timeout:
  - The counter increments every cycle in START and RUN.
  - When it equals TIMEOUT_CYCLES-1 and ap_done is not sampled that cycle: timeout=1 for one cycle, cN_ap_start=0, last=n, grant=0, bus released, state=IDLE, no done_pulse.
  - If done and timeout coincide, done wins.
- Request behaviour:
  - Dropping req mid-run does not abort the run.
  - A req still high after FINISH is serviced again subject to round-robin.
- cN_ap_idle is informational only; it is not used for sequencing.
- Only one cN_ap_start is ever high at a time.

Test Plan:
- Reset, then req=01; core 0 model: ready after 3 cycles, two SDA writes (0 then 1), one SCL write 0, done at cycle 10.
  - Required: grant=01 one cycle after req.
  - c0_ap_start high exactly until the ready cycle.
  - sda_o follows 1→0→1 and scl_o 1→0, each one cycle after its strobe.
  - done_pulse=01 for one cycle, then sda_o=scl_o=1 and grant=00.
- req=11 held continuously over three runs.
  - Required: grants alternate 01,10,01.
  - c1_ap_start is never high while grant=01.
- Core 1 asserts ap_ready and ap_done in the same cycle.
  - Required: FINISH follows directly; done_pulse=10; start is low the next cycle.
- TIMEOUT_CYCLES=16, core never asserts done.
  - Required: timeout pulse exactly 16 cycles after the START entry; no done_pulse; bus released.
  - The other requester is granted next.
- Non-granted core toggles its SDA/SCL ap_vld during the other core's run.
  - Required: sda_o and scl_o are unaffected.
- ap_rst asserted mid-RUN with sda_o=0.
  - Required: next cycle all outputs are at their reset values, sda_o=1.
  - After reset is released with req=11, core 0 wins.
